// File: rtl/galaksija_scandoubler.sv
// Line-doubling scan converter: 15 kHz mono raster in, 31 kHz raster out, ping-pong line buffer.
// Optional SCANLINE_DIM_EN: second repetition of each line is output at half intensity.
module galaksija_scandoubler #(
    parameter int DW       = 8,
    parameter int MAX_LINE = 512,
    parameter int HS_WIDTH = 15
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ce_in,
    input  logic [DW-1:0] in_dat,
    input  logic          in_hsync,
    input  logic          in_vsync,
    input  logic          in_blank,
    output logic [DW-1:0] out_dat,
    output logic          out_hsync,
    output logic          out_vsync,
    output logic          out_blank,
    output logic          locked
);
    localparam int AW = $clog2(MAX_LINE);
    localparam logic [AW:0] MAX_X = (AW+1)'(MAX_LINE);
    localparam logic [AW:0] HS_W  = (AW+1)'(HS_WIDTH);

    logic [AW:0]   in_x;
    logic [AW:0]   line_len;
    logic [AW:0]   new_len;
    logic [AW-1:0] out_x;
    logic          wr_bank;
    logic          phase;
    logic          hs_prev;
    logic          line_start;

    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [DW:0]   wr_data;
    logic [AW:0]   rd_addr;
    logic [DW:0]   rd_q;
    logic [DW:0]   mem [0:2*MAX_LINE-1];

    logic          hs_d;
    logic          vs_d;
    logic [DW-1:0] pix;
`ifdef SCANLINE_DIM_EN
    logic          ph_d;
`endif

    always_comb begin
        line_start = ce_in & hs_prev & ~in_hsync;
        new_len    = (in_x > MAX_X) ? MAX_X : in_x;
        wr_data    = {in_blank, in_dat};
        wr_en      = 1'b0;
        wr_addr    = {wr_bank, in_x[AW-1:0]};
        // The edge pixel opens the new line, so it goes to address 0 of the bank about to be written.
        if (line_start) begin
            wr_en   = 1'b1;
            wr_addr = {~wr_bank, {AW{1'b0}}};
        end else if (ce_in && (in_x < MAX_X)) begin
            wr_en = 1'b1;
        end
        rd_addr = {~wr_bank, out_x};
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

    // Input side: pixel counter, line-length measurement and lock detection.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            in_x     <= '0;
            line_len <= '0;
            wr_bank  <= 1'b0;
            locked   <= 1'b0;
            hs_prev  <= 1'b0;
        end else if (ce_in) begin
            hs_prev <= in_hsync;
            if (line_start) begin
                locked   <= (line_len != '0) && (new_len == line_len);
                line_len <= new_len;
                wr_bank  <= ~wr_bank;
                in_x     <= (AW+1)'(1);
            end else if (in_x < MAX_X) begin
                in_x <= in_x + 1'b1;
            end
        end
    end

    // Output side: runs every clk, restarted by each input line start.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_x <= '0;
            phase <= 1'b0;
        end else if (line_start) begin
            out_x <= '0;
            phase <= 1'b0;
        end else if (line_len == '0) begin
            out_x <= '0;
        end else if ({1'b0, out_x} == (line_len - 1'b1)) begin
            out_x <= '0;
            phase <= ~phase;
        end else begin
            out_x <= out_x + 1'b1;
        end
    end

    always_comb begin
`ifdef SCANLINE_DIM_EN
        pix = ph_d ? {1'b0, rd_q[DW-1:1]} : rd_q[DW-1:0];
`else
        pix = rd_q[DW-1:0];
`endif
    end

    // Sync/phase are delayed alongside the buffer read so everything lands on the same output clk.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hs_d      <= 1'b0;
            vs_d      <= 1'b1;
`ifdef SCANLINE_DIM_EN
            ph_d      <= 1'b0;
`endif
            out_dat   <= '0;
            out_hsync <= 1'b1;
            out_vsync <= 1'b1;
            out_blank <= 1'b1;
        end else begin
            hs_d <= ({1'b0, out_x} < HS_W);
            if (out_x == '0) begin
                vs_d <= in_vsync;
            end
`ifdef SCANLINE_DIM_EN
            ph_d <= phase;
`endif
            if (locked) begin
                out_dat   <= pix;
                out_blank <= rd_q[DW];
                out_hsync <= ~hs_d;
                out_vsync <= vs_d;
            end else begin
                out_dat   <= '0;
                out_blank <= 1'b1;
                out_hsync <= 1'b1;
                out_vsync <= 1'b1;
            end
        end
    end

endmodule
